// File: rtl/cla_pipe_adder_if.sv
// cla_pipe_adder_if -- operand/result bundle for cla_pipe_adder.
//   master (producer/consumer side): drives in_valid, a, b, c_in, sub;
//                                    receives out_valid, sum, c_out, ovf.
//   slave  (the adder):              the mirror image.
// WIDTH must match the adder's WIDTH.
interface cla_pipe_adder_if #(
   parameter int WIDTH = 64
);
   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             sub;
   logic             out_valid;
   logic [WIDTH-1:0] sum;
   logic             c_out;
   logic             ovf;

   modport master (
      output in_valid, a, b, c_in, sub,
      input  out_valid, sum, c_out, ovf
   );

   modport slave (
      input  in_valid, a, b, c_in, sub,
      output out_valid, sum, c_out, ovf
   );
endinterface

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder -- pipelined carry-lookahead adder/subtractor.
//   One GRP-bit group is resolved per stage; the inter-group carry is
//   registered, so latency is NSTG = WIDTH/GRP cycles at one op per cycle.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset, clears every register
//   ce   (only with CLA_PIPE_CE_EN defined) pipeline advance enable
//   io   cla_pipe_adder_if.slave: in_valid/a/b/c_in/sub in,
//        out_valid/sum/c_out/ovf out (registered)
// Optional feature macro: CLA_PIPE_CE_EN (adds ce; ce=0 freezes every stage).
module cla_pipe_adder #(
   parameter int WIDTH = 64,
   parameter int GRP   = 16
) (
   input  logic                clk,
   input  logic                rst,
`ifdef CLA_PIPE_CE_EN
   input  logic                ce,
`endif
   cla_pipe_adder_if.slave     io
);
   localparam int NSTG = WIDTH / GRP;
   localparam int NCL  = GRP / 4;

   typedef struct packed {
      logic [GRP-1:0] s;   // group sum
      logic           co;  // carry out of the group
      logic           cm;  // carry into the group's top bit (for ovf)
   } grp_res_t;

   // Two-level lookahead: 4-bit cluster P/G, then a cluster carry chain
   // built from those P/G terms; bit carries inside a cluster are expanded
   // from the cluster carry-in.
   function automatic grp_res_t grp_add(input logic [GRP-1:0] x,
                                        input logic [GRP-1:0] y,
                                        input logic           ci);
      logic [GRP-1:0] p, g, c;
      logic [NCL-1:0] cp, cg;
      logic [NCL:0]   cc;
      grp_res_t       r;
      p = x ^ y;
      g = x & y;
      for (int i = 0; i < NCL; i++) begin
         cp[i] = &p[4*i +: 4];
         cg[i] = g[4*i+3]
               | (p[4*i+3] & g[4*i+2])
               | (p[4*i+3] & p[4*i+2] & g[4*i+1])
               | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
      end
      cc[0] = ci;
      for (int i = 0; i < NCL; i++)
         cc[i+1] = cg[i] | (cp[i] & cc[i]);
      for (int i = 0; i < NCL; i++) begin
         c[4*i]   = cc[i];
         c[4*i+1] = g[4*i] | (p[4*i] & cc[i]);
         c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i])
                  | (p[4*i+1] & p[4*i] & cc[i]);
         c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1])
                  | (p[4*i+2] & p[4*i+1] & g[4*i])
                  | (p[4*i+2] & p[4*i+1] & p[4*i] & cc[i]);
      end
      r.s  = p ^ c;
      r.co = cc[NCL];
      r.cm = c[GRP-1];
      return r;
   endfunction

   // Rank k holds the operands entering stage k; groups below k are already
   // resolved into s_q[k], groups at and above k are still waiting (skew).
   // s_q[NSTG] is the output rank: all groups aligned (deskew).
   logic [NSTG-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [NSTG-1:0]            cy_q, cy_d;
   logic [NSTG:0][WIDTH-1:0]   s_q, s_d;
   logic [NSTG:0]              vld_q, vld_d;
   logic                       co_q, co_d, ovf_q, ovf_d;
   logic                       adv;
   grp_res_t                   res [NSTG];

`ifdef CLA_PIPE_CE_EN
   assign adv = ce;
`else
   assign adv = 1'b1;
`endif

   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      cy_d  = cy_q;
      s_d   = s_q;
      vld_d = vld_q;
      for (int k = 0; k < NSTG; k++)
         res[k] = grp_add(a_q[k][k*GRP +: GRP], b_q[k][k*GRP +: GRP], cy_q[k]);

      // Subtract as A + ~B + ~borrow.
      a_d[0]   = io.a;
      b_d[0]   = io.sub ? ~io.b : io.b;
      cy_d[0]  = io.c_in ^ io.sub;
      s_d[0]   = '0;
      vld_d[0] = io.in_valid;

      for (int k = 0; k < NSTG-1; k++) begin
         a_d[k+1]  = a_q[k];
         b_d[k+1]  = b_q[k];
         cy_d[k+1] = res[k].co;
      end
      for (int k = 0; k < NSTG; k++) begin
         s_d[k+1]                = s_q[k];
         s_d[k+1][k*GRP +: GRP]  = res[k].s;
         vld_d[k+1]              = vld_q[k];
      end
      co_d  = res[NSTG-1].co;
      ovf_d = res[NSTG-1].co ^ res[NSTG-1].cm;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         cy_q  <= '0;
         s_q   <= '0;
         vld_q <= '0;
         co_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else if (adv) begin
         a_q   <= a_d;
         b_q   <= b_d;
         cy_q  <= cy_d;
         s_q   <= s_d;
         vld_q <= vld_d;
         co_q  <= co_d;
         ovf_q <= ovf_d;
      end
   end

   assign io.out_valid = vld_q[NSTG];
   assign io.sum       = s_q[NSTG];
   assign io.c_out     = co_q;
   assign io.ovf       = ovf_q;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder -- bench for cla_pipe_adder: a 64/16 instance driven with
// directed vectors and a 32/8 instance driven with random ops, both checked
// every cycle against an arithmetic reference, plus literal expectations.
module tb_cla_pipe_adder;
   logic clk, rst, ce;
   int   total = 0;
   int   bad   = 0;

   cla_pipe_adder_if #(.WIDTH(64)) m64 ();
   cla_pipe_adder_if #(.WIDTH(32)) m32 ();

   cla_pipe_adder #(.WIDTH(64), .GRP(16)) dut64 (
      .clk(clk), .rst(rst),
`ifdef CLA_PIPE_CE_EN
      .ce(ce),
`endif
      .io(m64.slave));

   cla_pipe_adder #(.WIDTH(32), .GRP(8)) dut32 (
      .clk(clk), .rst(rst),
`ifdef CLA_PIPE_CE_EN
      .ce(ce),
`endif
      .io(m32.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   typedef struct packed {
      logic        v;
      logic [63:0] s;
      logic        co;
      logic        ov;
   } exp_t;

   // Reference: plain integer arithmetic on n-bit operands.
   function automatic exp_t model(input int n, input logic v,
                                  input logic [63:0] a, input logic [63:0] b,
                                  input logic ci, input logic sb);
      exp_t r;
      logic [65:0]        full, mask;
      logic signed [65:0] sa, sbv, tr, pw, half, cis;
      pw   = 66'sd1;
      pw   = pw << n;
      half = pw >>> 1;
      mask = pw - 66'sd1;
      cis  = $signed({65'b0, ci});
      sa   = $signed({2'b0, a});
      sbv  = $signed({2'b0, b});
      if (a[n-1]) sa  = sa - pw;
      if (b[n-1]) sbv = sbv - pw;
      if (sb) begin
         full = {2'b0, a} - {2'b0, b} - {65'b0, ci};
         r.co = ({2'b0, a} >= ({2'b0, b} + {65'b0, ci}));
         tr   = sa - sbv - cis;
      end else begin
         full = {2'b0, a} + {2'b0, b} + {65'b0, ci};
         r.co = full[n];
         tr   = sa + sbv + cis;
      end
      r.s  = 64'(full & mask);
      r.ov = (tr >= half) || (tr < -half);
      r.v  = v;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Op-level delay line: an op leaves after NSTG=4 advancing edges.
   exp_t p64 [4];
   exp_t p32 [4];
   exp_t o64, o32;

   initial begin
      for (int i = 0; i < 4; i++) begin
         p64[i] = '0;
         p32[i] = '0;
      end
      o64 = '0;
      o32 = '0;
   end

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            p64[i] = '0;
            p32[i] = '0;
         end
         o64 = '0;
         o32 = '0;
      end else if (ce) begin
         o64 = p64[3];
         o32 = p32[3];
         for (int i = 3; i > 0; i--) begin
            p64[i] = p64[i-1];
            p32[i] = p32[i-1];
         end
         p64[0] = model(64, m64.in_valid, m64.a, m64.b, m64.c_in, m64.sub);
         p32[0] = model(32, m32.in_valid, {32'b0, m32.a}, {32'b0, m32.b},
                        m32.c_in, m32.sub);
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_v64",  {63'b0, m64.out_valid}, 64'd0);
         chk("rst_s64",  m64.sum, 64'd0);
         chk("rst_co64", {63'b0, m64.c_out}, 64'd0);
         chk("rst_ov64", {63'b0, m64.ovf}, 64'd0);
         chk("rst_v32",  {63'b0, m32.out_valid}, 64'd0);
         chk("rst_s32",  {32'b0, m32.sum}, 64'd0);
      end else begin
         chk("v64", {63'b0, m64.out_valid}, {63'b0, o64.v});
         if (o64.v) begin
            chk("sum64", m64.sum, o64.s);
            chk("co64",  {63'b0, m64.c_out}, {63'b0, o64.co});
            chk("ov64",  {63'b0, m64.ovf}, {63'b0, o64.ov});
         end
         chk("v32", {63'b0, m32.out_valid}, {63'b0, o32.v});
         if (o32.v) begin
            chk("sum32", {32'b0, m32.sum}, o32.s);
            chk("co32",  {63'b0, m32.c_out}, {63'b0, o32.co});
            chk("ov32",  {63'b0, m32.ovf}, {63'b0, o32.ov});
         end
      end
   end

   task automatic set64(input logic v, input logic [63:0] a, input logic [63:0] b,
                        input logic ci, input logic sb);
      m64.in_valid = v;
      m64.a        = a;
      m64.b        = b;
      m64.c_in     = ci;
      m64.sub      = sb;
   endtask

   task automatic lit_out(input string nm, input logic [63:0] es,
                          input logic eco, input logic eov);
      chk({nm, "_v"},  {63'b0, m64.out_valid}, 64'd1);
      chk({nm, "_s"},  m64.sum, es);
      chk({nm, "_co"}, {63'b0, m64.c_out}, {63'b0, eco});
      chk({nm, "_ov"}, {63'b0, m64.ovf}, {63'b0, eov});
   endtask

   // Present one op at edge t, check the hand-computed result after t+4.
   task automatic lit(input string nm, input logic [63:0] a, input logic [63:0] b,
                      input logic ci, input logic sb, input logic [63:0] es,
                      input logic eco, input logic eov);
      @(posedge clk); #1;
      set64(1'b1, a, b, ci, sb);
      @(posedge clk); #1;
      m64.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      lit_out(nm, es, eco, eov);
   endtask

   initial begin
      rst = 1'b1;
      ce  = 1'b1;
      set64(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
      m32.in_valid = 1'b0;
      m32.a = '0; m32.b = '0; m32.c_in = 1'b0; m32.sub = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      fork
         begin : directed
            lit("wrap",   64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
            lit("ovfpos", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                64'h8000_0000_0000_0000, 1'b0, 1'b1);
            lit("sub57",  64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
            lit("sub75b", 64'd7, 64'd5, 1'b1, 1'b1, 64'd1, 1'b1, 1'b0);

            // Stream 1+1, 2+2, gap, 3+3.
            @(posedge clk); #1 set64(1'b1, 64'd1, 64'd1, 1'b0, 1'b0);
            @(posedge clk); #1 set64(1'b1, 64'd2, 64'd2, 1'b0, 1'b0);
            @(posedge clk); #1 set64(1'b0, 64'd9, 64'd9, 1'b0, 1'b0);
            @(posedge clk); #1 set64(1'b1, 64'd3, 64'd3, 1'b0, 1'b0);
            @(posedge clk); #1 m64.in_valid = 1'b0;
            @(posedge clk); @(negedge clk); lit_out("str1", 64'd2, 1'b0, 1'b0);
            @(posedge clk); @(negedge clk); lit_out("str2", 64'd4, 1'b0, 1'b0);
            @(posedge clk); @(negedge clk);
            chk("str_gap", {63'b0, m64.out_valid}, 64'd0);
            @(posedge clk); @(negedge clk); lit_out("str3", 64'd6, 1'b0, 1'b0);

            // Three ops in flight, then reset coinciding with a valid op.
            @(posedge clk); #1 set64(1'b1, 64'd10, 64'd1, 1'b0, 1'b0);
            @(posedge clk); #1 set64(1'b1, 64'd20, 64'd2, 1'b0, 1'b0);
            @(posedge clk); #1 set64(1'b1, 64'd30, 64'd3, 1'b0, 1'b0);
            @(posedge clk); #1 begin
               rst = 1'b1;
               set64(1'b1, 64'd40, 64'd4, 1'b0, 1'b0);
            end
            #1 chk("rst_drop", {63'b0, m64.out_valid}, 64'd0);
            @(posedge clk); #1 begin
               rst = 1'b0;
               m64.in_valid = 1'b0;
            end
            lit("after_rst", 64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF,
                1'b1, 1'b0, 64'h0000_0002_0000_0000, 1'b0, 1'b0);
            lit("neg_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
                64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
`ifdef CLA_PIPE_CE_EN
            // Freeze for 3 edges mid-flight: result at t+7.
            @(posedge clk); #1 set64(1'b1, 64'd100, 64'd23, 1'b0, 1'b0);
            @(posedge clk); #1 m64.in_valid = 1'b0;
            @(posedge clk); #1 ce = 1'b0;
            repeat (3) @(posedge clk);
            #1 ce = 1'b1;
            repeat (3) @(posedge clk);
            @(negedge clk); lit_out("ce_hold", 64'd123, 1'b0, 1'b0);
`endif
            repeat (6) @(posedge clk);
         end
         begin : random32
            for (int i = 0; i < 10000; i++) begin
               @(posedge clk); #1;
               m32.in_valid = ($urandom_range(0, 7) != 0);
               m32.a        = (i % 97 == 0) ? 32'hFFFF_FFFF : $urandom;
               m32.b        = (i % 89 == 0) ? 32'h8000_0000 : $urandom;
               m32.c_in     = $urandom_range(0, 1) == 1;
               m32.sub      = $urandom_range(0, 1) == 1;
            end
            @(posedge clk); #1 m32.in_valid = 1'b0;
            repeat (6) @(posedge clk);
         end
      join

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
